// File: rtl/icb_rsp_gen.sv
// ICB slave responder bank: NCH independent channels. Each channel queues up to
// DEPTH commands and returns in-order responses after a fixed latency.
module icb_rsp_gen #(
  parameter int          NCH   = 5,
  parameter int          AW    = 32,
  parameter int          DW    = 32,
  parameter int          DEPTH = 4,
  parameter int          LAT   = 2,
  parameter logic [31:0] SEED  = 32'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                bp_en,
  input  logic                err_en,
  input  logic [AW-1:0]       err_addr,
  input  logic [NCH-1:0]      icb_cmd_valid,
  input  logic [NCH*AW-1:0]   icb_cmd_addr,
  input  logic [NCH-1:0]      icb_cmd_read,
  input  logic [NCH*DW-1:0]   icb_cmd_wdata,
  input  logic [NCH*DW/8-1:0] icb_cmd_wmask,
  output logic [NCH-1:0]      icb_cmd_ready,
  output logic [NCH-1:0]      icb_rsp_valid,
  output logic [NCH-1:0]      icb_rsp_err,
  output logic [NCH*DW-1:0]   icb_rsp_rdata,
  input  logic [NCH-1:0]      icb_rsp_ready,
  output logic [NCH*16-1:0]   txn_cnt
);

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_ONES = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_ECHO = 2'd3
  } mode_e;

  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = PW + 1;
  localparam int             AGW     = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [AGW-1:0] LAT_AGE = AGW'(LAT);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]    TAPS    = 32'h8020_0003;

  // Write payload is accepted and dropped; the reduction just keeps it referenced.
  logic unused_cmd;
  assign unused_cmd = ^{icb_cmd_wdata, icb_cmd_wmask};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [31:0] SEED_SUM = SEED + 32'(c);
    localparam logic [31:0] SEED_C   = (SEED_SUM == 32'h0) ? 32'h1 : SEED_SUM;

    logic [31:0]    lfsr;
    logic [31:0]    lfsr_next;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [15:0]    done_cnt;
    logic [AGW-1:0] age       [DEPTH];
    logic [DW-1:0]  mem_rdata [DEPTH];
    logic           mem_err   [DEPTH];

    logic [AW-1:0]  addr;
    logic           full;
    logic           empty;
    logic           ready;
    logic           accept;
    logic           head_valid;
    logic           pop;
    logic [DW-1:0]  push_rdata;
    logic           push_err;

    assign addr = icb_cmd_addr[c*AW +: AW];

    // Ready looks only at registered occupancy and LFSR, never at this cycle's pop.
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign ready      = !rst && !full && (!bp_en || lfsr[0]);
    assign accept     = icb_cmd_valid[c] && ready;
    assign head_valid = !rst && !empty && (age[rd_ptr] == LAT_AGE);
    assign pop        = head_valid && icb_rsp_ready[c];

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
    assign push_err  = err_en && (addr == err_addr);

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
      push_rdata = '0;
      if (icb_cmd_read[c]) begin
        case (mode_e'(mode))
          MODE_ONES: push_rdata = '1;
          MODE_LFSR: push_rdata = DW'(lfsr);
          MODE_ECHO: push_rdata = DW'(addr);
          default:   push_rdata = '0;
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (rst) begin
        lfsr     <= SEED_C;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        done_cnt <= '0;
        for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
        lfsr <= lfsr_next;
        // Ages saturate at LAT; a fresh push overrides its slot below.
        for (int i = 0; i < DEPTH; i++) begin
          if (age[i] != LAT_AGE) age[i] <= age[i] + 1'b1;
        end
        if (accept) begin
          age[wr_ptr] <= '0;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          done_cnt <= done_cnt + 16'd1;
        end
        if (accept && !pop) begin
          count <= count + 1'b1;
        end else if (!accept && pop) begin
          count <= count - 1'b1;
        end
      end
    end

    // NOTE: payload storage has no reset; an entry is only read after a push
    // wrote it, and occupancy is tracked by the reset counters above.
    always_ff @(posedge clk) begin
      if (accept) begin
        mem_rdata[wr_ptr] <= push_rdata;
        mem_err[wr_ptr]   <= push_err;
      end
    end

    assign icb_cmd_ready[c]          = ready;
    assign icb_rsp_valid[c]          = head_valid;
    assign icb_rsp_err[c]            = head_valid && mem_err[rd_ptr];
    assign icb_rsp_rdata[c*DW +: DW] = head_valid ? mem_rdata[rd_ptr] : '0;
    assign txn_cnt[c*16 +: 16]       = done_cnt;
  end

endmodule

// File: tb/tb_icb_rsp_gen.sv
// Self-checking bench for icb_rsp_gen: directed scenarios plus randomized traffic,
// all compared every cycle against a timestamped per-channel response queue model.
module tb_icb_rsp_gen;

  localparam int          NCH   = 5;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          LAT   = 2;
  localparam logic [31:0] SEED  = 32'h1;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          mode;
  logic                bp_en;
  logic                err_en;
  logic [AW-1:0]       err_addr;
  logic [NCH-1:0]      icb_cmd_valid;
  logic [NCH*AW-1:0]   icb_cmd_addr;
  logic [NCH-1:0]      icb_cmd_read;
  logic [NCH*DW-1:0]   icb_cmd_wdata;
  logic [NCH*DW/8-1:0] icb_cmd_wmask;
  logic [NCH-1:0]      icb_cmd_ready;
  logic [NCH-1:0]      icb_rsp_valid;
  logic [NCH-1:0]      icb_rsp_err;
  logic [NCH*DW-1:0]   icb_rsp_rdata;
  logic [NCH-1:0]      icb_rsp_ready;
  logic [NCH*16-1:0]   txn_cnt;

  always #5 clk = ~clk;

  icb_rsp_gen #(
    .NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .LAT(LAT), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .bp_en(bp_en), .err_en(err_en),
    .err_addr(err_addr), .icb_cmd_valid(icb_cmd_valid), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wmask(icb_cmd_wmask), .icb_cmd_ready(icb_cmd_ready),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_err(icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_ready(icb_rsp_ready), .txn_cnt(txn_cnt)
  );

  // Reference model: each pending response carries the cycle it becomes due.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } ent_t;

  ent_t        m_q [NCH][DEPTH];
  int          m_head [NCH];
  int          m_size [NCH];
  logic [31:0] m_lfsr [NCH];
  logic [15:0] m_cnt  [NCH];
  int          cyc;

  logic        d_acc     [NCH];
  int          d_acc_cyc [NCH];
  int          obs_ch;
  logic [32:0] obs_q [$];
  int          obs_cyc [$];

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] seed_of(input int c);
    logic [31:0] s;
    s = SEED + 32'(c);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] sh;
    sh = v >> 1;
    return v[0] ? (sh ^ TAPS) : sh;
  endfunction

  function automatic logic exp_ready(input int c);
    return !rst && (m_size[c] < DEPTH) && (!bp_en || m_lfsr[c][0]);
  endfunction

  function automatic logic exp_valid(input int c);
    return !rst && (m_size[c] > 0) && (cyc >= m_q[c][m_head[c]].due);
  endfunction

  function automatic logic [31:0] exp_data(input int c);
    logic [31:0] a;
    a = icb_cmd_addr[c*AW +: AW];
    if (!icb_cmd_read[c]) return 32'h0;
    case (mode)
      2'd0:    return 32'h0;
      2'd1:    return 32'hFFFF_FFFF;
      2'd2:    return m_lfsr[c];
      default: return a;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_head[c] = 0;
      m_size[c] = 0;
      m_cnt[c]  = '0;
      m_lfsr[c] = seed_of(c);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_head[c] = 0;
        m_size[c] = 0;
        m_cnt[c]  = '0;
        m_lfsr[c] = seed_of(c);
      end else begin
        logic er;
        logic ev;
        int   slot;
        er = exp_ready(c);
        ev = exp_valid(c);
        if (ev && icb_rsp_ready[c]) begin
          m_head[c] = (m_head[c] + 1) % DEPTH;
          m_size[c] = m_size[c] - 1;
          m_cnt[c]  = m_cnt[c] + 16'd1;
        end
        if (er && icb_cmd_valid[c]) begin
          slot = (m_head[c] + m_size[c]) % DEPTH;
          m_q[c][slot].rdata = exp_data(c);
          m_q[c][slot].err   = err_en && (icb_cmd_addr[c*AW +: AW] == err_addr);
          m_q[c][slot].due   = cyc + 1 + LAT;
          m_size[c] = m_size[c] + 1;
        end
        m_lfsr[c] = lfsr_step(m_lfsr[c]);
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NCH; c++) begin
      logic ev;
      ent_t e;
      ev = exp_valid(c);
      check($sformatf("cmd_ready[%0d]", c), icb_cmd_ready[c], exp_ready(c));
      check($sformatf("rsp_valid[%0d]", c), icb_rsp_valid[c], ev);
      if (ev) begin
        e = m_q[c][m_head[c]];
        check($sformatf("rsp_rdata[%0d]", c), icb_rsp_rdata[c*DW +: DW], e.rdata);
        check($sformatf("rsp_err[%0d]", c), icb_rsp_err[c], e.err);
      end else if (rst) begin
        check($sformatf("rst_rdata[%0d]", c), icb_rsp_rdata[c*DW +: DW], 0);
        check($sformatf("rst_err[%0d]", c), icb_rsp_err[c], 0);
      end
      check($sformatf("txn_cnt[%0d]", c), txn_cnt[c*16 +: 16], m_cnt[c]);
      d_acc[c]     = icb_cmd_valid[c] && icb_cmd_ready[c];
      d_acc_cyc[c] = cyc;
      if (c == obs_ch && icb_rsp_valid[c] && icb_rsp_ready[c]) begin
        obs_q.push_back({icb_rsp_err[c], icb_rsp_rdata[c*DW +: DW]});
        obs_cyc.push_back(cyc);
      end
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are compared at negedge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic issue(input int c, input logic [31:0] a, input logic rd, output int t);
    icb_cmd_valid[c]          = 1'b1;
    icb_cmd_addr[c*AW +: AW]  = a;
    icb_cmd_read[c]           = rd;
    t = -1;
    for (int k = 0; k < 50 && t < 0; k++) begin
      step();
      if (d_acc[c]) t = d_acc_cyc[c];
    end
    icb_cmd_valid[c] = 1'b0;
    if (t < 0) check($sformatf("issue_timeout[%0d]", c), 0, 1);
  endtask

  task automatic randomize_inputs();
    for (int c = 0; c < NCH; c++) begin
      icb_cmd_valid[c]         = 1'($urandom_range(0, 1));
      icb_cmd_addr[c*AW +: AW] = ($urandom_range(0, 3) == 0) ? 32'h2000 : ($urandom & 32'hFFFC);
      icb_cmd_read[c]          = ($urandom_range(0, 3) != 0);
      icb_cmd_wdata[c*DW +: DW] = $urandom;
      icb_cmd_wmask[c*DW/8 +: DW/8] = 4'($urandom);
      icb_rsp_ready[c]         = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic clear_obs(input int c);
    obs_ch = c;
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    int t;
    int t5;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    obs_ch = -1;
    for (int c = 0; c < NCH; c++) begin
      d_acc[c]     = 1'b0;
      d_acc_cyc[c] = 0;
    end
    rst = 1'b1; mode = 2'd0; bp_en = 1'b0; err_en = 1'b0; err_addr = '0;
    icb_cmd_valid = '1; icb_cmd_addr = '0; icb_cmd_read = '1;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = '1;
    model_reset();

    // Reset held two cycles with commands pending.
    repeat (2) step();
    check("rst_txn_cnt", txn_cnt, 0);
    rst = 1'b0;
    icb_cmd_valid = '0;
    #1;
    check("rst_release_ready", icb_cmd_ready, {NCH{1'b1}});

    // Latency on ch0.
    clear_obs(0);
    issue(0, 32'h1000, 1'b1, t);
    repeat (6) step();
    check("lat_count", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("lat_cycle", obs_cyc[0], t + 3);
      check("lat_rsp", obs_q[0], 0);
    end
    check("lat_txn_cnt0", txn_cnt[15:0], 1);

    // Fill ch1 with responses stalled, then drain.
    clear_obs(1);
    mode = 2'd1;
    icb_rsp_ready[1] = 1'b0;
    icb_cmd_valid[1] = 1'b1;
    icb_cmd_addr[1*AW +: AW] = 32'h3000;
    icb_cmd_read[1] = 1'b1;
    repeat (4) step();
    check("full_ready_low", icb_cmd_ready[1], 0);
    step();
    check("full_ready_still_low", icb_cmd_ready[1], 0);
    icb_rsp_ready[1] = 1'b1;
    t5 = -1;
    for (int k = 0; k < 20 && t5 < 0; k++) begin
      step();
      if (d_acc[1]) t5 = d_acc_cyc[1];
    end
    icb_cmd_valid[1] = 1'b0;
    if (t5 < 0) check("full_fifth_timeout", 0, 1);
    repeat (6) step();
    check("full_nrsp", obs_q.size(), 5);
    for (int i = 0; i < obs_q.size() && i < 5; i++)
      check($sformatf("full_rsp%0d", i), obs_q[i], {1'b0, 32'hFFFF_FFFF});
    if (obs_q.size() >= 4) begin
      check("full_consecutive", obs_cyc[3] - obs_cyc[0], 3);
      check("full_fifth_cycle", t5, obs_cyc[0] + 1);
    end

    // Address echo and error injection on ch2.
    clear_obs(2);
    mode = 2'd3; err_en = 1'b1; err_addr = 32'h2000;
    issue(2, 32'h2000, 1'b1, t);
    issue(2, 32'h2004, 1'b1, t);
    issue(2, 32'h2000, 1'b0, t);
    repeat (6) step();
    check("echo_nrsp", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("echo_rsp0", obs_q[0], {1'b1, 32'h2000});
      check("echo_rsp1", obs_q[1], {1'b0, 32'h2004});
      check("echo_rsp2", obs_q[2], {1'b1, 32'h0});
    end

    // Random traffic, LFSR data with backpressure, then fully random controls.
    obs_ch = -1;
    mode = 2'd2; bp_en = 1'b1; err_en = 1'b1; err_addr = 32'h2000;
    repeat (1000) begin
      randomize_inputs();
      step();
    end
    repeat (300) begin
      mode   = 2'($urandom_range(0, 3));
      bp_en  = 1'($urandom_range(0, 1));
      err_en = 1'($urandom_range(0, 1));
      randomize_inputs();
      step();
    end
    icb_cmd_valid = '0; icb_rsp_ready = '1; bp_en = 1'b0;
    repeat (12) step();

    // Reset with three entries outstanding on ch4.
    clear_obs(4);
    mode = 2'd1;
    icb_rsp_ready[4] = 1'b0;
    repeat (3) issue(4, 32'h4000, 1'b1, t);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_valid", icb_rsp_valid[4], 0);
    check("midrst_txn_cnt", txn_cnt[4*16 +: 16], 0);
    icb_rsp_ready[4] = 1'b1;
    issue(4, 32'h4004, 1'b1, t);
    repeat (6) step();
    check("midrst_nrsp", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("midrst_cycle", obs_cyc[0], t + 3);
      check("midrst_rsp", obs_q[0], {1'b0, 32'hFFFF_FFFF});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icb_rsp_gen.md
# icb_rsp_gen

Parametrised, synthesizable ICB slave responder bank that stands in for the core's peripheral and memory buses (PPI, CLINT, PLIC, FIO, MEM) during CPU-top simulation and emulation. Each of NCH independent channels accepts ICB commands with optional pseudo-random backpressure. It queues up to DEPTH outstanding transactions and returns in-order responses after a fixed latency. Response data follows a selectable mode (all-zero, all-ones, pseudo-random, address echo), with address-matched error injection.

## Interface
- NCH, 5, number of ICB channels
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- DEPTH, 4, outstanding transactions per channel (power of 2, ≥2)
- LAT, 2, extra response latency in cycles (≥0)
- SEED, 32'h1, LFSR base seed
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- mode  in  2  0 zero, 1 all-ones, 2 LFSR, 3 address echo
- bp_en  in  1  enable random cmd_ready backpressure
- err_en  in  1  enable error injection
- err_addr  in  AW  address that returns rsp_err=1
- icb_cmd_valid  in  NCH  per-channel command valid
- icb_cmd_addr  in  NCH*AW  command address, channel c at [c*AW +: AW]
- icb_cmd_read  in  NCH  1 read, 0 write
- icb_cmd_wdata  in  NCH*DW  write data (ignored)
- icb_cmd_wmask  in  NCH*DW/8  write mask (ignored)
- icb_cmd_ready  out  NCH  command ready
- icb_rsp_valid  out  NCH  response valid
- icb_rsp_err  out  NCH  response error
- icb_rsp_rdata  out  NCH*DW  response data
- icb_rsp_ready  in  NCH  response ready
- txn_cnt  out  NCH*16  completed responses per channel, wraps

## Operation
- Per channel: 32-bit Galois LFSR, taps 32'h80200003. Seed is SEED+c; a zero seed is replaced by 1. The LFSR advances every cycle out of reset.
- cmd_ready = !full && (!bp_en || lfsr[0]). Full disables acceptance even if a pop happens in the same cycle.
- Accept = cmd_valid && cmd_ready. On accept, push {rdata, err, age=0}.
- rdata on read: mode 0 gives 0; mode 1 gives all-ones; mode 2 gives the LFSR value in the accept cycle, zero-extended/truncated to DW; mode 3 gives cmd_addr zero-extended/truncated to DW. rdata on write is always 0.
- err = err_en && (cmd_addr == err_addr), for both reads and writes.
- Each stored entry's age increments every cycle and saturates at LAT.
- rsp_valid = !empty && head.age == LAT. rsp_err and rsp_rdata come from the head entry.
- Pop on rsp_valid && rsp_ready. On pop, txn_cnt increments mod 2^16.
- Once asserted, rsp_valid and its data hold stable until the handshake. mode, err_* and bp_en changes affect only later accepts.
- Responses are strictly in accept order per channel. Channels are fully independent.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.

## Timing
- Reset (rst=1 at posedge): FIFOs empty, ages 0, LFSRs reloaded, txn_cnt 0. Outputs while rst=1: cmd_ready 0, rsp_valid 0, rsp_err 0, rsp_rdata 0.
- Reset mid-operation discards all outstanding entries; no responses are issued for them.
- Latency: accept in cycle t gives earliest rsp_valid in cycle t+1+LAT. With LAT=0 this is the next cycle.
- Throughput: one accept and one response per channel per cycle with bp_en=0 and rsp_ready=1.
- Full: after DEPTH accepts without pops, cmd_ready=0. It returns to 1 on the cycle after the first pop.
- Empty: rsp_valid=0. No combinational path exists from cmd_valid to rsp_valid.
- cmd_ready depends only on registered state, with no combinational dependence on cmd_valid or rsp_ready.

## Test plan
- Reset: rst=1 for 2 cycles with cmd_valid=1 → cmd_ready=0, rsp_valid=0, txn_cnt=0. After release with bp_en=0, cmd_ready=1 in the first cycle.
- Latency: LAT=2, mode=0, ch0 read of 0x1000 accepted at cycle t, rsp_ready=1 → rsp_valid exactly at t+3 for one cycle, rdata=0, err=0, txn_cnt[0]=1.
- Full/order: mode=1, rsp_ready=0, 5 back-to-back reads on ch1 → 4 accepted, cmd_ready=0 from the 5th cycle. Raising rsp_ready gives 4 responses of 32'hFFFFFFFF on consecutive cycles, then the 5th is accepted.
- Echo/error: mode=3, err_en=1, err_addr=0x2000, reads on ch2 of 0x2000 then 0x2004 → rdata 0x2000 with err=1, then rdata 0x2004 with err=0. A write to 0x2000 → rdata 0 with err=1.
- Random: mode=2, bp_en=1, 1000 cycles of random valid/addr/rsp_ready on all channels → no lost or duplicated responses, per-channel order kept, rdata matches the bench LFSR model. rsp_valid and data stay stable while rsp_ready=0.
- Reset mid-flight: 3 entries outstanding on ch4, rst=1 for one cycle → rsp_valid=0 next cycle and txn_cnt[4]=0. A new read afterwards responds after LAT+1 cycles.
